pcode_grant_decoder: RTL and testbench

Consumer end of the priority-encoder path. Accepts the 3-bit priority code produced by the priority encoder over a valid/ready handshake, decodes it into a registered one-hot grant, and holds that grant until the owning requester releases it or a tenure timeout expires. A mandatory idle gap follows each grant. It sits between the request encoder and the shared resource and enforces one owner at a time.

---
 rtl/pcode_grant_decoder.sv | 132 +++++++++++++
 tb/tb_pcode_grant_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcode_grant_decoder.sv
// rtl/pcode_grant_decoder.sv - decodes a priority code into a held one-hot grant with tenure timeout and idle gap
module pcode_grant_decoder #(
  parameter int N       = 4,
  parameter int CW      = 3,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pcode_valid,
  input  logic [CW-1:0] pcode,
  output logic          pcode_ready,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] owner,
  output logic          busy,
  output logic          timeout_pulse,
  output logic          code_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tenure_q, tenure_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [CW-1:0] owner_q, owner_d;
  logic          tp_q, tp_d;
  logic          ce_q, ce_d;

  logic          accept;
  logic          code_in_range;
  logic          code_too_big;
  logic          owner_done;
  logic          tenure_max;
  logic          gap_last;
  logic [N-1:0]  code_onehot;

  assign accept        = pcode_valid & pcode_ready;
  assign code_in_range = (pcode != '0) && (pcode <= CW'(N));
  assign code_too_big  = pcode > CW'(N);
  // grant_q is one-hot on the owner, so masking done with it honours only the owner's bit
  assign owner_done    = |(done & grant_q);
  assign tenure_max    = tenure_q == TW'(TIMEOUT - 1);
  assign gap_last      = gap_q == GW'(GAP - 1);

  always_comb begin
    code_onehot = '0;
    for (int i = 0; i < N; i++) begin
      code_onehot[i] = (pcode == CW'(i + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tenure_q <= '0;
      gap_q    <= '0;
      grant_q  <= '0;
      owner_q  <= '0;
      tp_q     <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tenure_q <= tenure_d;
      gap_q    <= gap_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      tp_q     <= tp_d;
      ce_q     <= ce_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && code_in_range) state_d = S_GRANT;
      S_GRANT: if (owner_done || tenure_max) state_d = S_GAP;
      S_GAP:   if (gap_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    owner_d  = owner_q;
    tenure_d = tenure_q;
    gap_d    = gap_q;
    tp_d     = 1'b0;
    ce_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && code_in_range) begin
          grant_d  = code_onehot;
          owner_d  = pcode;
          tenure_d = '0;
        end else if (accept && code_too_big) begin
          ce_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (owner_done || tenure_max) begin
          grant_d = '0;
          owner_d = '0;
          gap_d   = '0;
          // release by the owner wins over a timeout on the same edge
          tp_d    = ~owner_done;
        end else begin
          tenure_d = tenure_q + TW'(1);
        end
      end
      S_GAP: begin
        if (!gap_last) gap_d = gap_q + GW'(1);
      end
      default: begin
        grant_d = '0;
        owner_d = '0;
      end
    endcase
  end

  assign pcode_ready   = (state_q == S_IDLE) & ~rst;
  assign busy          = state_q != S_IDLE;
  assign grant         = grant_q;
  assign owner         = owner_q;
  assign timeout_pulse = tp_q;
  assign code_err      = ce_q;

endmodule

// File: tb/tb_pcode_grant_decoder.sv
// tb/tb_pcode_grant_decoder.sv - scoreboard bench for pcode_grant_decoder
module tb_pcode_grant_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcode_valid = 1'b0;
  logic [2:0] pcode = 3'd0;
  logic       pcode_ready;
  logic [3:0] done = 4'd0;
  logic [3:0] grant;
  logic [2:0] owner;
  logic       busy;
  logic       timeout_pulse;
  logic       code_err;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb[$];
  logic [10:0] e;

  pcode_grant_decoder #(.N(4), .CW(3), .TIMEOUT(16), .GAP(1)) dut (
    .clk(clk), .rst(rst), .pcode_valid(pcode_valid), .pcode(pcode),
    .pcode_ready(pcode_ready), .done(done), .grant(grant), .owner(owner),
    .busy(busy), .timeout_pulse(timeout_pulse), .code_err(code_err)
  );

  always #5 clk = ~clk;

  // expected output vector: {grant, owner, busy, ready, timeout_pulse, code_err}
  function automatic logic [10:0] mk(input logic [3:0] g, input logic [2:0] o,
                                     input logic b, input logic r,
                                     input logic tp, input logic ce);
    return {g, o, b, r, tp, ce};
  endfunction

  function automatic logic [10:0] obs();
    return {grant, owner, busy, pcode_ready, timeout_pulse, code_err};
  endfunction

  function automatic logic [10:0] gnt(input int c);
    logic [3:0] g;
    g = 4'b0001 << (c - 1);
    return mk(g, 3'(c), 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [10:0] idle_e(input logic ce);
    return mk(4'd0, 3'd0, 1'b0, 1'b1, 1'b0, ce);
  endfunction

  function automatic logic [10:0] gap_e(input logic tp);
    return mk(4'd0, 3'd0, 1'b1, 1'b0, tp, 1'b0);
  endfunction

  // called at a falling edge: apply inputs, queue the expected post-edge outputs
  task automatic drive(input logic v, input logic [2:0] c, input logic [3:0] d,
                       input logic [10:0] exp_v);
    pcode_valid = v;
    pcode = c;
    done = d;
    sb.push_back(exp_v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    sb.push_back(mk(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_held got %b exp %b", obs(), e);
    end
    rst = 1'b0;
    #1;
    sb.push_back(idle_e(1'b0));
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs(), e);
    end
    @(negedge clk);
  endtask

  task automatic test_normal;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1'b1, 3'd3, 4'b0000, gnt(3));
      else if (i < 6)  drive(1'b0, 3'($urandom_range(0, 7)), 4'b0000, gnt(3));
      else if (i == 6) drive(1'b0, 3'd0, 4'b0100, gap_e(1'b0));
      else             drive(1'b0, 3'd0, 4'b0000, idle_e(1'b0));
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL normal cyc %0d got %b exp %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 18; i++) begin
      if (i == 0)       drive(1'b1, 3'd1, 4'b0000, gnt(1));
      else if (i < 16)  drive(1'b0, 3'd0, 4'b0000, gnt(1));
      else if (i == 16) drive(1'b0, 3'd0, 4'b0000, gap_e(1'b1));
      else              drive(1'b0, 3'd0, 4'b0000, idle_e(1'b0));
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL timeout cyc %0d got %b exp %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 18; i++) begin
      if (i == 0)       drive(1'b1, 3'd1, 4'b0000, gnt(1));
      else if (i < 16)  drive(1'b0, 3'd0, 4'b1110, gnt(1));
      else if (i == 16) drive(1'b0, 3'd0, 4'b0001, gap_e(1'b0));
      else              drive(1'b0, 3'd0, 4'b0000, idle_e(1'b0));
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL simul_to cyc %0d got %b exp %b", i, obs(), e);
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 0)      drive(1'b1, 3'd2, 4'b0000, gnt(2));
      else if (i < 7)  drive(1'b0, 3'd0, (i[0] ? 4'b1000 : 4'b1101), gnt(2));
      else if (i == 7) drive(1'b0, 3'd0, 4'b0010, gap_e(1'b0));
      else             drive(1'b0, 3'd0, 4'b0000, idle_e(1'b0));
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL nonowner_done cyc %0d got %b exp %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_codes;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(1'b1, 3'd0, 4'b0000, idle_e(1'b0));
        1: drive(1'b1, 3'd5, 4'b0000, idle_e(1'b1));
        2: drive(1'b1, 3'd7, 4'b0000, idle_e(1'b1));
        3: drive(1'b1, 3'd4, 4'b0000, gnt(4));
        4: drive(1'b0, 3'd6, 4'b0000, gnt(4));
        5: drive(1'b0, 3'd0, 4'b1000, gap_e(1'b0));
        default: drive(1'b0, 3'd0, 4'b0000, idle_e(1'b0));
      endcase
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL codes cyc %0d got %b exp %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      if (i < 3)       drive(1'b1, 3'd2, 4'b0000, gnt(2));
      else if (i == 3) drive(1'b1, 3'd2, 4'b0010, gap_e(1'b0));
      else if (i == 4) drive(1'b1, 3'd2, 4'b0000, idle_e(1'b0));
      else if (i == 5) drive(1'b1, 3'd2, 4'b0000, gnt(2));
      else if (i == 6) drive(1'b0, 3'd0, 4'b0010, gap_e(1'b0));
      else             drive(1'b0, 3'd0, 4'b0000, idle_e(1'b0));
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL handshake cyc %0d got %b exp %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 3'd3, 4'b0000, gnt(3));
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rstmid_grant got %b exp %b", obs(), e);
    end
    pcode_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    sb.push_back(mk(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rstmid_async got %b exp %b", obs(), e);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, 4'b0000, idle_e(1'b0));
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rstmid_after cyc %0d got %b exp %b", i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_timeout;
    test_simultaneous;
    test_codes;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
